// File: rtl/shift_pkg.sv
// Shared opcodes, FSM states and saturation constant for the multi-cycle shift sequencer.
package shift_pkg;

  localparam logic [2:0] SH_LSL = 3'b000;
  localparam logic [2:0] SH_LSR = 3'b001;
  localparam logic [2:0] SH_ASR = 3'b010;
  localparam logic [2:0] SH_ROL = 3'b011;
  localparam logic [2:0] SH_ROR = 3'b100;

  // Linear shifts beyond this leave only fill bits, so the amount is clamped here.
  localparam int SH_SAT = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves value by 0..STEP_MAX positions and reports the last bit out.
module shift_step
  import shift_pkg::*;
#(
  parameter  int DATA_W   = 8,
  parameter  int STEP_MAX = 4,
  localparam int AMT_W    = $clog2(STEP_MAX + 1)
) (
  input  logic [DATA_W-1:0] value,
  input  logic [2:0]        op,
  input  logic [AMT_W-1:0]  amount,
  output logic [DATA_W-1:0] shifted,
  output logic              last_out
);

  // An extra guard bit beside the value catches the last bit shifted out; ASR keeps the sign as fill.
  always_comb begin
    shifted  = value;
    last_out = 1'b0;
    case (op)
      SH_LSL: {last_out, shifted} = {1'b0, value} << amount;
      SH_LSR: {shifted, last_out} = {value, 1'b0} >> amount;
      SH_ASR: {shifted, last_out} = $signed({value, 1'b0}) >>> amount;
      SH_ROL: begin
        shifted  = (value << amount) | (value >> (DATA_W - int'(amount)));
        last_out = shifted[0];
      end
      SH_ROR: begin
        shifted  = (value >> amount) | (value << (DATA_W - int'(amount)));
        last_out = shifted[DATA_W-1];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer applying up to STEP_MAX positions per clock.
// Optional carry_out/zero_out flags are built when SHIFT_FLAGS_EN is defined.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int STEP_MAX = 4,
  parameter int SHAMT_W  = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [DATA_W-1:0]  operand,
  output logic               busy,
  output logic               done,
`ifdef SHIFT_FLAGS_EN
  output logic               carry_out,
  output logic               zero_out,
`endif
  output logic [DATA_W-1:0]  result
);

  localparam int CNT_W = $clog2(SH_SAT + 1);
  localparam int AMT_W = $clog2(STEP_MAX + 1);

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  acc;
  logic [CNT_W-1:0]   remaining;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   start_n;
  logic [AMT_W-1:0]   step;
  logic               last_step;
  logic [DATA_W-1:0]  step_val;
  logic               step_last;

  // Normalized amount: rotates wrap modulo the width, linear shifts saturate, others do nothing.
  always_comb begin
    start_n = '0;
    case (op)
      SH_ROL, SH_ROR: start_n = CNT_W'(shamt[2:0]);
      SH_LSL, SH_LSR, SH_ASR:
        start_n = (shamt > SHAMT_W'(SH_SAT)) ? CNT_W'(SH_SAT) : CNT_W'(shamt);
      default: start_n = '0;
    endcase
  end

  assign step      = (remaining > CNT_W'(STEP_MAX)) ? AMT_W'(STEP_MAX) : AMT_W'(remaining);
  assign last_step = (remaining == CNT_W'(step));

  shift_step #(
    .DATA_W   (DATA_W),
    .STEP_MAX (STEP_MAX)
  ) u_step (
    .value    (acc),
    .op       (op_q),
    .amount   (step),
    .shifted  (step_val),
    .last_out (step_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = (start_n == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (last_step) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  // Result (and flags) only change on entry to DONE, so they hold until the next command finishes.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      op_q      <= '0;
      result    <= '0;
`ifdef SHIFT_FLAGS_EN
      carry_out <= 1'b0;
      zero_out  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc       <= operand;
            op_q      <= op;
            remaining <= start_n;
            if (start_n == '0) begin
              result <= operand;
`ifdef SHIFT_FLAGS_EN
              carry_out <= 1'b0;
              zero_out  <= (operand == '0);
`endif
            end
          end
        end
        ST_SHIFT: begin
          acc       <= step_val;
          remaining <= remaining - CNT_W'(step);
          if (last_step) begin
            result <= step_val;
`ifdef SHIFT_FLAGS_EN
            carry_out <= step_last;
            zero_out  <= (step_val == '0);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer; flag outputs are checked when SHIFT_FLAGS_EN is defined.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [4:0] shamt;
  logic [7:0] operand;
  logic       busy;
  logic       done;
  logic [7:0] result;
`ifdef SHIFT_FLAGS_EN
  logic       carry_out;
  logic       zero_out;
`endif

  typedef struct {
    logic [7:0] res;
    logic       carry;
    logic       zero;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_done = 1'b0;

  shift_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .shamt     (shamt),
    .operand   (operand),
    .busy      (busy),
    .done      (done),
`ifdef SHIFT_FLAGS_EN
    .carry_out (carry_out),
    .zero_out  (zero_out),
`endif
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drives one start cycle; the expected response is queued when push is set.
  task automatic applyStimulus(input logic [2:0] o, input logic [4:0] s, input logic [7:0] v,
                               input logic [7:0] res, input logic carry, input int lat, input bit push);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; shamt = s; operand = v;
    if (push) begin
      e.res = res; e.carry = carry; e.zero = (res == 8'h00); e.due = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000; shamt = 5'd0; operand = 8'h00;
  endtask

  task automatic waitDone();
    int k = 0;
    while (sb.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("sb_drain", sb.size(), 0);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (prev_done) checkOutput("done_pulse_width", done, 1'b0);
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1'b1, 1'b0);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("done_cycle", cyc, e.due);
`ifdef SHIFT_FLAGS_EN
        checkOutput("carry_out", carry_out, e.carry);
        checkOutput("zero_out", zero_out, e.zero);
`endif
      end
    end
    prev_done = done;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; shamt = 5'd0; operand = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    checkOutput("reset_result", result, 8'h00);
`ifdef SHIFT_FLAGS_EN
    checkOutput("reset_carry", carry_out, 1'b0);
    checkOutput("reset_zero", zero_out, 1'b0);
`endif
    rst = 1'b0;

    // LSL 0x81 by 3 -> 0x08, busy across T+1..T+2
    applyStimulus(3'b000, 5'd3, 8'h81, 8'h08, 1'b0, 2, 1'b1);
    checkOutput("lsl_busy_t1", busy, 1'b1);
    @(posedge clk); #1;
    checkOutput("lsl_busy_t2", busy, 1'b1);
    @(posedge clk); #1;
    checkOutput("lsl_busy_t3", busy, 1'b0);
    waitDone();

    // ASR 0x90 by 20 saturates to 9 -> 0xFF, sign bit as carry
    applyStimulus(3'b010, 5'd20, 8'h90, 8'hFF, 1'b1, 4, 1'b1);
    waitDone();

    // ROR 0x01 by 11 (n=3) -> 0x20
    applyStimulus(3'b100, 5'd11, 8'h01, 8'h20, 1'b0, 2, 1'b1);
    waitDone();

    // ROL 0xA5 by 8 (n=0) -> unchanged
    applyStimulus(3'b011, 5'd8, 8'hA5, 8'hA5, 1'b0, 1, 1'b1);
    waitDone();

    // Pass-through op
    applyStimulus(3'b111, 5'd5, 8'h3C, 8'h3C, 1'b0, 1, 1'b1);
    waitDone();

    // Reset mid-command: aborted with no done, outputs back to reset values
    applyStimulus(3'b001, 5'd31, 8'hF0, 8'h00, 1'b0, 4, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_result", result, 8'h00);
    checkOutput("abort_done", done, 1'b0);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // LSR 0xF0 by 4 -> 0x0F
    applyStimulus(3'b001, 5'd4, 8'hF0, 8'h0F, 1'b0, 2, 1'b1);
    waitDone();

    // LSR 0xF0 by 31 (n=9) -> 0x00, with an ignored start while busy
    applyStimulus(3'b001, 5'd31, 8'hF0, 8'h00, 1'b0, 4, 1'b1);
    start = 1'b1; op = 3'b000; shamt = 5'd1; operand = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000; shamt = 5'd0; operand = 8'h00;
    waitDone();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("result_hold", result, 8'h00);
    end
    checkOutput("idle_after_hold", busy, 1'b0);

    repeat (3) @(posedge clk);
    checkOutput("sb_final_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
